// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - b_in, LSB first, one full-subtractor
// cell per clock with a borrow flip-flop and a start/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; operands captured on accept
// S_SHIFT | one result bit per cycle, WIDTH cycles, busy=1
// S_DONE  | done=1 for one cycle, result registers valid
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic x, y, d, br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    x        = a_sr[0];
    y        = b_sr[0];
    d        = x ^ y ^ br;
    br_next  = (~x & y) | (~(x ^ y) & br);
    res_next = {d, res_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      b_out  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= b_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          res_sr <= res_next;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= br_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // br here is the borrow into the MSB; br_next is the borrow out
            busy  <= 1'b0;
            done  <= 1'b1;
            diff  <= res_next;
            b_out <= br_next;
            ovf   <= br ^ br_next;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: arithmetic/timing model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         b_in = 1'b0;
  logic         busy, done, b_out, ovf;
  logic [W-1:0] diff;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .b_in(b_in),
    .busy(busy), .done(done), .diff(diff), .b_out(b_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  function automatic res_t sub_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    res_t r;
    int u, s;
    u = int'(x) - int'(y) - int'(bi);
    s = int'($signed(x)) - int'($signed(y)) - int'(bi);
    r.d  = u[W-1:0];
    r.bo = (u < 0);
    r.ov = (s < -(1 << (W-1))) || (s > (1 << (W-1)) - 1);
    return r;
  endfunction

  // Model: phase 0 idle, 1..W busy, W+1 done
  int           m_phase;
  res_t         m_pend;
  logic [W-1:0] m_diff;
  logic         m_bout, m_ovf;
  logic         exp_busy, exp_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_pend  <= '0;
      m_diff  <= '0;
      m_bout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      if (m_phase == 0) begin
        if (start) begin
          m_phase <= 1;
          m_pend  <= sub_model(a, b, b_in);
        end
      end else if (m_phase == W + 1) begin
        m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
      if (m_phase == W) begin
        m_diff <= m_pend.d;
        m_bout <= m_pend.bo;
        m_ovf  <= m_pend.ov;
      end
    end
  end

  assign exp_busy = (m_phase >= 1) && (m_phase <= W);
  assign exp_done = (m_phase == W + 1);

  always @(negedge clk) begin
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("diff", diff, m_diff);
    check("b_out", b_out, m_bout);
    check("ovf", ovf, m_ovf);
    check("busy_and_done", busy & done, 1'b0);
  end

  always @(posedge clk) begin
    #1;
    if (done === 1'b1) done_cnt++;
  end

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < 30);
  endtask

  task automatic check_result(input string name, input logic [W-1:0] ed, input logic ebo, input logic eov);
    check({name, "_diff"}, diff, ed);
    check({name, "_bout"}, b_out, ebo);
    check({name, "_ovf"}, ovf, eov);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic bi, input logic [W-1:0] ed, input logic ebo, input logic eov);
    int j;
    @(negedge clk);
    a = x; b = y; b_in = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, busy, 1'b1);
    wait_done(j);
    check({name, "_lat"}, j, W);
    check_result(name, ed, ebo, eov);
  endtask

  typedef struct {
    logic [W-1:0] x, y;
    logic         bi;
    logic [W-1:0] ed;
    logic         ebo, eov;
  } vec_t;

  initial begin
    int j, d0;
    vec_t b2b[4];
    b2b[0] = '{8'h10, 8'h03, 1'b0, 8'h0D, 1'b0, 1'b0};
    b2b[1] = '{8'hAA, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0};
    b2b[2] = '{8'h01, 8'h02, 1'b1, 8'hFE, 1'b1, 1'b0};
    b2b[3] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};

    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check_result("rst", 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    run_op("basic", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run_op("underflow", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run_op("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run_op("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run_op("bin", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start pulsed and operands changed while busy
    @(negedge clk);
    d0 = done_cnt;
    a = 8'h40; b = 8'h0F; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'hEE; b_in = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'hFF; b = 8'h01;
    wait_done(j);
    check("ignored_start_lat", j, W - 3);
    check_result("ignored_start", 8'h31, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    check("ignored_start_ndone", done_cnt - d0, 1);

    // back-to-back with start held high
    @(negedge clk);
    a = b2b[0].x; b = b2b[0].y; b_in = b2b[0].bi; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_done(j);
      check($sformatf("b2b%0d_period", i), j, (i == 0) ? W + 1 : W + 2);
      check_result($sformatf("b2b%0d", i), b2b[i].ed, b2b[i].ebo, b2b[i].eov);
      if (i < 3) begin
        a = b2b[i+1].x; b = b2b[i+1].y; b_in = b2b[i+1].bi;
      end else begin
        start = 1'b0;
      end
    end

    // asynchronous reset mid-operation
    repeat (2) @(negedge clk);
    a = 8'h33; b = 8'h11; b_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check_result("midrst", 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (15) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    run_op("fresh", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
